// File: rtl/alu_pkg.sv
// Shared ALU op codes and arbiter FSM encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_NOT_A = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

    localparam int DATA_W = 4;
    localparam int SEL_W  = 3;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU; unsupported op codes yield zero with err set.
module alu
    import alu_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              err
);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (sel)
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_NOT_A: result = ~a;
            default:  err    = 1'b1;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end that serialises operations onto one shared ALU.
//   state | meaning
//   IDLE  | waiting; ready offered to the granted requester
//   EXEC  | captured operands drive the ALU; result registered on exit
//   RESP  | rsp_valid high until the consumer takes the result
module alu_arbiter
    import alu_pkg::*;
#(
    parameter logic FAIR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [SEL_W-1:0]  req1_sel,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy
);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic              last_id;
    logic [SEL_W-1:0]  op_sel;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_id;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_err;

    // Requester 1 wins only when alone, or in fair mode when 0 was served last.
    always_comb begin
        grant1 = req1_valid && (!req0_valid || (FAIR && !last_id));
        grant0 = req0_valid && !grant1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy       = 1'b0;
                req0_ready = rst_n && grant0;
                req1_ready = rst_n && grant1;
                accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
                if (accept) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_id    <= 1'b1;
            op_sel     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                op_id   <= req1_ready;
                last_id <= req1_ready;
                op_sel  <= req1_ready ? req1_sel : req0_sel;
                op_a    <= req1_ready ? req1_a   : req0_a;
                op_b    <= req1_ready ? req1_b   : req0_b;
            end
            // Response fields only move on EXEC exit, so they hold through RESP.
            if (state == ST_EXEC) begin
                rsp_id     <= op_id;
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_err    <= alu_err;
            end
        end
    end

    alu u_alu (
        .sel    (op_sel),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result),
        .zero   (alu_zero),
        .err    (alu_err)
    );

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FAIR, 1, 1 = round-robin grant between requesters; 0 = fixed priority, requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  arbiter accepts requester 0 operation this cycle.
REQ-006 req0_sel  input  3  requester 0 ALU op code.
REQ-007 req0_a  input  4  requester 0 operand A.
REQ-008 req0_b  input  4  requester 0 operand B.
REQ-009 req1_valid, req1_ready, req1_sel, req1_a, req1_b  same directions, widths and meanings for requester 1.
REQ-010 rsp_valid  output  1  response holds a completed result.
REQ-011 rsp_ready  input  1  response consumer accepts the result.
REQ-012 rsp_id  output  1  requester that issued the operation.
REQ-013 rsp_result  output  4  ALU result.
REQ-014 rsp_zero  output  1  rsp_result == 0.
REQ-015 rsp_err  output  1  op code was unsupported (101, 110, 111).
REQ-016 busy  output  1  FSM not in IDLE.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, RESP; IDLE->EXEC on accept; EXEC->RESP unconditionally; RESP->IDLE when rsp_valid && rsp_ready.
REQ-018 Op codes SHALL be 000 add, 001 sub, 010 and, 011 or, 100 not A; all arithmetic modulo 16, carry/borrow discarded.
REQ-019 reqN_ready SHALL be 1 only in IDLE and only for the granted requester; at most one ready high per cycle.
REQ-020 Accept SHALL occur when reqN_valid && reqN_ready; sel, a, b and id are captured in that cycle.
REQ-021 Grant with one valid SHALL go to that requester regardless of FAIR.
REQ-022 Grant with both valid and FAIR=1 SHALL go to the requester not served last; FAIR=0 SHALL go to requester 0.
REQ-023 Last-served pointer SHALL update only on accept.
REQ-024 In EXEC the captured operands SHALL drive the ALU and its output, zero and err flags SHALL be registered into the response fields.
REQ-025 rsp_valid SHALL assert in RESP only; latency SHALL be exactly 2 cycles from the accept edge to rsp_valid high.
REQ-026 rsp_id, rsp_result, rsp_zero, rsp_err SHALL stay stable while rsp_valid && !rsp_ready.
REQ-027 Unsupported op codes SHALL complete normally with rsp_result=0, rsp_zero=1, rsp_err=1.
REQ-028 Throughput SHALL be one operation per 3 cycles minimum; no new accept while busy.
REQ-029 Requester valid deasserting before accept SHALL have no effect; no ready is issued for a dropped request.

Reset
REQ-030 rst_n low at a clock edge SHALL force IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0, both ready=0 in the following cycle.
REQ-031 Last-served pointer SHALL reset to 1 so requester 0 wins the first contended grant.
REQ-032 Reset during EXEC or RESP SHALL discard the in-flight operation; no response is produced for it.

Structure
REQ-033 Op-code constants and FSM state encoding SHALL live in a shared package alu_pkg.
REQ-034 The datapath SHALL be one instance of the existing combinational ALU module; no arithmetic is duplicated in the arbiter.

Verification
REQ-035 Single op: req0 sel=000 a=9 b=8 -> rsp_valid 2 cycles after accept, rsp_result=1, rsp_id=0, rsp_zero=0.
REQ-036 Contention FAIR=1: both valid continuously, req0 sub 3-3, req1 or 5|2 -> grants 0,1,0,1; responses id0 result 0 zero=1, id1 result 7.
REQ-037 Contention FAIR=0: both valid continuously -> every grant to requester 0; req1_ready never high.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, op not A=4'hA -> rsp_result=5 held stable, busy=1, no ready high until handshake.
REQ-039 Illegal op: sel=110 a=F b=F -> rsp_result=0, rsp_zero=1, rsp_err=1.
REQ-040 Reset mid-op: rst_n low in EXEC -> next cycle IDLE, rsp_valid=0, no response; next request served with 2-cycle latency.
